// File: rtl/sram_arb2_pkg.sv
// rtl/sram_arb2_pkg.sv - state encodings and port index constants shared by sram_arb2 and its picker
package sram_arb2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/sram_arb2_rr.sv
// rtl/sram_arb2_rr.sv - 2-way round-robin picker; SRAM_ARB_FIXED_PRIO_EN makes port 0 always win
module sram_arb2_rr
    import sram_arb2_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic gnt0,
    output logic gnt1
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;
    assign gnt0 = req0;
    assign gnt1 = req1 & ~req0;
`else
    // rr_ptr names the port that wins when both request
    assign gnt0 = req0 & (~req1 | (rr_ptr == PORT0));
    assign gnt1 = req1 & (~req0 | (rr_ptr == PORT1));
`endif

endmodule

// File: rtl/sram_arb2.sv
// rtl/sram_arb2.sv - two-port arbiter for a single-port sync SRAM with bounded locked bursts
// Optional: SRAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module sram_arb2
    import sram_arb2_pkg::*;
#(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          sram_csn,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    localparam int            CW         = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST);
    localparam bit            LOCK_EN    = (MAX_BURST > 1);

    arb_state_t    state, state_d;
    logic          rr_ptr, rr_d;
    logic [CW-1:0] burst_cnt, cnt_d, cnt_inc;
    logic          own_hit0, own_hit1, arb_en;
    logic          arb_gnt0, arb_gnt1;
    logic          gnt0, gnt1;

    // An owner that stops requesting gives up the lock and arbitration runs this same cycle
    assign own_hit0 = (state == ST_OWN0) & req0;
    assign own_hit1 = (state == ST_OWN1) & req1;
    assign arb_en   = hresetn & ~own_hit0 & ~own_hit1;
    assign cnt_inc  = burst_cnt + CW'(1);

    sram_arb2_rr u_rr (
        .req0   (req0 & arb_en),
        .req1   (req1 & arb_en),
        .rr_ptr (rr_ptr),
        .gnt0   (arb_gnt0),
        .gnt1   (arb_gnt1)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            rr_ptr    <= PORT0;
            burst_cnt <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_d;
            burst_cnt <= cnt_d;
            rvalid0   <= gnt0 & ~we0;
            rvalid1   <= gnt1 & ~we1;
        end
    end

    always_comb begin
        state_d = state;
        rr_d    = rr_ptr;
        cnt_d   = burst_cnt;
        gnt0    = hresetn & (own_hit0 | arb_gnt0);
        gnt1    = hresetn & (own_hit1 | arb_gnt1);

        case (state)
            ST_OWN0, ST_OWN1: begin
                if (own_hit0 || own_hit1) begin
                    cnt_d = cnt_inc;
                    rr_d  = other_port(own_hit0 ? PORT0 : PORT1);
                    if (!(own_hit0 ? lock0 : lock1) || cnt_inc == BURST_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (arb_gnt0) begin
            rr_d = other_port(PORT0);
            if (lock0 && LOCK_EN) begin
                state_d = ST_OWN0;
                cnt_d   = CW'(1);
            end
        end else if (arb_gnt1) begin
            rr_d = other_port(PORT1);
            if (lock1 && LOCK_EN) begin
                state_d = ST_OWN1;
                cnt_d   = CW'(1);
            end
        end
    end

    // Idle cycles park the SRAM pins at deselected, all-zero values
    always_comb begin
        ack0     = gnt0;
        ack1     = gnt1;
        sram_csn = ~(gnt0 | gnt1);
        sram_wen = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (gnt0) begin
            sram_wen = ~we0;
            sram_a   = addr0;
            sram_d   = wdata0;
        end else if (gnt1) begin
            sram_wen = ~we1;
            sram_a   = addr1;
            sram_d   = wdata1;
        end
    end

    assign rdata0 = sram_q;
    assign rdata1 = sram_q;

endmodule

// File: tb/tb_sram_arb2.sv
// tb/tb_sram_arb2.sv - directed self-checking bench for sram_arb2 with a behavioural SRAM
module tb_sram_arb2;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, rvalid0, rvalid1, sram_csn, sram_wen;
    logic [DW-1:0] rdata0, rdata1, sram_d;
    logic [DW-1:0] sram_q = '0;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [DW-1:0] DAT_A = 32'hAAAA_0020;
    localparam logic [DW-1:0] DAT_B = 32'hBBBB_0021;

    always #5 hclk = ~hclk;

    always @(posedge hclk) begin
        if (!sram_csn) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    sram_arb2 #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
        .sram_q(sram_q)
    );

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        step();
        #3;
        n_checks++; if (ack0 !== 1'b0)     begin n_fail++; $display("FAIL reset_ack0 got %b want 0", ack0); end
        n_checks++; if (ack1 !== 1'b0)     begin n_fail++; $display("FAIL reset_ack1 got %b want 0", ack1); end
        n_checks++; if (sram_csn !== 1'b1) begin n_fail++; $display("FAIL reset_csn got %b want 1", sram_csn); end
        n_checks++; if (sram_wen !== 1'b1) begin n_fail++; $display("FAIL reset_wen got %b want 1", sram_wen); end
        n_checks++; if (sram_a !== '0)     begin n_fail++; $display("FAIL reset_a got %h want 0", sram_a); end
        n_checks++; if (sram_d !== '0)     begin n_fail++; $display("FAIL reset_d got %h want 0", sram_d); end
        n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b%b want 00", rvalid0, rvalid1); end
        step();
        hresetn = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h010; wdata0 = 32'h2021_1212;
        #4;
        n_checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL wr_ack got %b%b want 10", ack0, ack1); end
        n_checks++; if (sram_csn !== 1'b0 || sram_wen !== 1'b0) begin n_fail++; $display("FAIL wr_pins csn=%b wen=%b want 0 0", sram_csn, sram_wen); end
        n_checks++; if (sram_a !== 12'h010) begin n_fail++; $display("FAIL wr_addr got %h want 010", sram_a); end
        n_checks++; if (sram_d !== 32'h2021_1212) begin n_fail++; $display("FAIL wr_data got %h want 20211212", sram_d); end
        step();
        we0 = 1'b0;
        #4;
        n_checks++; if (ack0 !== 1'b1 || sram_wen !== 1'b1) begin n_fail++; $display("FAIL rd_issue ack0=%b wen=%b want 1 1", ack0, sram_wen); end
        n_checks++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid got %b want 0", rvalid0); end
        step();
        req0 = 1'b0;
        #4;
        n_checks++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid0 got %b want 1", rvalid0); end
        n_checks++; if (rdata0 !== 32'h2021_1212) begin n_fail++; $display("FAIL rd_data0 got %h want 20211212", rdata0); end
        n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid1 got %b want 0", rvalid1); end
        n_checks++; if (sram_csn !== 1'b1 || sram_a !== '0) begin n_fail++; $display("FAIL idle_pins csn=%b a=%h want 1 000", sram_csn, sram_a); end
        step();
    endtask

    task automatic preload();
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h020; wdata0 = DAT_A;
        step();
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h021; wdata1 = DAT_B;
        step();
        req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        step();
    endtask

`ifndef SRAM_ARB_FIXED_PRIO_EN
    task automatic test_round_robin();
        logic [4:0] e_a0, e_a1, e_v0, e_v1;
        e_a0 = 5'b00101; e_a1 = 5'b01010; e_v0 = 5'b01010; e_v1 = 5'b10100;
        addr0 = 12'h020; addr1 = 12'h021;
        for (int i = 0; i < 5; i++) begin
            req0 = (i < 4); req1 = (i < 4);
            #4;
            n_checks++; if (ack0 !== e_a0[i] || ack1 !== e_a1[i]) begin n_fail++; $display("FAIL rr_ack c%0d got %b%b want %b%b", i, ack0, ack1, e_a0[i], e_a1[i]); end
            n_checks++; if (rvalid0 !== e_v0[i] || rvalid1 !== e_v1[i]) begin n_fail++; $display("FAIL rr_rvalid c%0d got %b%b want %b%b", i, rvalid0, rvalid1, e_v0[i], e_v1[i]); end
            if (e_v0[i]) begin n_checks++; if (rdata0 !== DAT_A) begin n_fail++; $display("FAIL rr_rdata0 c%0d got %h want %h", i, rdata0, DAT_A); end end
            if (e_v1[i]) begin n_checks++; if (rdata1 !== DAT_B) begin n_fail++; $display("FAIL rr_rdata1 c%0d got %h want %h", i, rdata1, DAT_B); end end
            step();
        end
    endtask

    task automatic test_locked_burst();
        logic [6:0] e_a0;
        logic [AW-1:0] a;
        e_a0 = 7'b1101111;
        a = 12'h100;
        addr1 = 12'h021; we1 = 1'b0; we0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0 = (i < 7); addr0 = a; wdata0 = 32'hD000_0000 | 32'(a); lock0 = (a != 12'h105);
            req1 = (i < 5);
            #4;
            if (i < 7) begin
                n_checks++; if (ack0 !== e_a0[i] || ack1 !== ~e_a0[i]) begin n_fail++; $display("FAIL burst_ack c%0d got %b%b want %b%b", i, ack0, ack1, e_a0[i], ~e_a0[i]); end
                if (e_a0[i]) begin n_checks++; if (sram_a !== a || sram_wen !== 1'b0) begin n_fail++; $display("FAIL burst_addr c%0d got %h wen=%b want %h 0", i, sram_a, sram_wen, a); end end
            end
            n_checks++; if (rvalid1 !== (i == 5)) begin n_fail++; $display("FAIL burst_rvalid1 c%0d got %b want %b", i, rvalid1, (i == 5)); end
            if (i == 5) begin n_checks++; if (rdata1 !== DAT_B) begin n_fail++; $display("FAIL burst_rdata1 got %h want %h", rdata1, DAT_B); end end
            if (i < 7 && e_a0[i]) a = a + 12'h1;
            step();
        end
        lock0 = 1'b0; we0 = 1'b0;
    endtask
`else
    task automatic test_fixed_prio();
        addr0 = 12'h020; addr1 = 12'h021; we0 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #4;
            n_checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL fixed_ack c%0d got %b%b want 10", i, ack0, ack1); end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask
`endif

    task automatic test_lock_drop();
        req0 = 1'b1; lock0 = 1'b1; we0 = 1'b1; addr0 = 12'h200; wdata0 = 32'h1234_5678;
        #4;
        n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL drop_first got %b want 1", ack0); end
        step();
        req0 = 1'b0; lock0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h021;
        #4;
        n_checks++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin n_fail++; $display("FAIL drop_same_cycle got %b%b want 01", ack0, ack1); end
        n_checks++; if (sram_a !== 12'h021) begin n_fail++; $display("FAIL drop_addr got %h want 021", sram_a); end
        step();
        req0 = 1'b1; addr0 = 12'h020;
        #4;
        n_checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL drop_idle_arb got %b%b want 10", ack0, ack1); end
        n_checks++; if (rvalid1 !== 1'b1 || rdata1 !== DAT_B) begin n_fail++; $display("FAIL drop_rvalid1 got %b %h want 1 %h", rvalid1, rdata1, DAT_B); end
        step();
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_reset_midburst();
        req0 = 1'b1; lock0 = 1'b1; we0 = 1'b0; addr0 = 12'h020; req1 = 1'b0;
        #4;
        n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL mid_lock_grant got %b want 1", ack0); end
        step();
        n_checks++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got %b want 1", rvalid0); end
        req1 = 1'b1;
        hresetn = 1'b0;
        #1;
        n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid_clr got %b%b want 00", rvalid0, rvalid1); end
        n_checks++; if (sram_csn !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b0) begin n_fail++; $display("FAIL mid_csn got csn=%b ack=%b%b want 1 00", sram_csn, ack0, ack1); end
        step();
        hresetn = 1'b1; lock0 = 1'b0;
        #4;
        n_checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL post_reset_first got %b%b want 10", ack0, ack1); end
        step();
        #4;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        n_checks++; if (ack0 !== 1'b0 || ack1 !== 1'b1) begin n_fail++; $display("FAIL post_reset_second got %b%b want 01", ack0, ack1); end
`else
        n_checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL post_reset_second got %b%b want 10", ack0, ack1); end
`endif
        step();
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        preload();
`ifndef SRAM_ARB_FIXED_PRIO_EN
        test_round_robin();
        test_locked_burst();
`else
        test_fixed_prio();
`endif
        step();
        test_lock_drop();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
